mul_sequencer: RTL

- Iterative shift-add multiplier controller for the EX stage; executes the MUL operation over multiple cycles instead of a single-cycle multiplier.
- Stalls the pipeline while busy and presents the low WIDTH bits of op1*op2 (RV32 MUL semantics; signed and unsigned give identical low bits).
- Sits beside the ALU; the EX stage raises start_i when the ALU control decodes a MUL.

---
 rtl/mul_sequencer_if.sv | 23 ++
 rtl/mul_sequencer.sv | 113 +++++++++++
 2 files changed

// File: rtl/mul_sequencer_if.sv
// Pipeline <-> iterative multiplier handshake: start/flush and operands in, stall/done/result out.
// Signal suffixes are named from the sequencer's point of view.
interface mul_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic             flush_i;
  logic [WIDTH-1:0] op1_i;
  logic [WIDTH-1:0] op2_i;
  logic             stall_o;
  logic             done_o;
  logic [WIDTH-1:0] result_o;

  modport master (
    output start_i, flush_i, op1_i, op2_i,
    input  stall_o, done_o, result_o
  );

  modport slave (
    input  start_i, flush_i, op1_i, op2_i,
    output stall_o, done_o, result_o
  );
endinterface

// File: rtl/mul_sequencer.sv
// Shift-add MUL sequencer: WIDTH+1 cycles from accept to a one-cycle done pulse (fewer with EARLY_OUT).
// Backpressure: stall_o holds the pipeline from the accepting cycle through RUN; released in DONE.
module mul_sequencer #(
  parameter int WIDTH     = 32,
  parameter bit EARLY_OUT = 1'b0
) (
  input  logic           clk_i,
  input  logic           rst_i,
  mul_sequencer_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CW-1:0]    count_q, count_d;
  logic             done_q, done_d;

  logic             accept;
  logic             last_iter;
  logic             enter_done;
  logic [WIDTH-1:0] mplier_shr;

  assign accept     = (state_q == IDLE) && bus.start_i && !bus.flush_i;
  assign mplier_shr = mplier_q >> 1;

  // Early-out looks at the multiplier after this cycle's shift: nothing left to add.
  assign last_iter  = (state_q == RUN) &&
                      ((count_q == CW'(WIDTH - 1)) || (EARLY_OUT && (mplier_shr == '0)));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (last_iter) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.flush_i) begin
      state_d = IDLE;
    end
  end

  always_comb begin
    bus.stall_o  = !rst_i && (accept || (state_q == RUN));
    bus.done_o   = done_q;
    bus.result_o = result_q;
  end

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    if (accept) begin
      acc_d    = '0;
      mcand_d  = bus.op1_i;
      mplier_d = bus.op2_i;
      count_d  = '0;
    end else if (state_q == RUN) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_shr;
      count_d  = count_q + CW'(1);
    end
  end

  // A flush on the final iteration lands in IDLE, so the old result survives.
  assign enter_done = (state_d == DONE);

  always_comb begin
    done_d   = enter_done;
    result_d = enter_done ? acc_d : result_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

endmodule
